// File: rtl/axis_lab_pkg.sv
// Shared definitions for the power-of-3 stream lab: checker states, the
// tstrb-to-bytemask expansion and the sequence multiplier used by generator and checker.
package axis_lab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest supported strobe (512-bit data); callers zero-extend and truncate.
  localparam int MAX_STRB_W = 64;
  localparam int unsigned POW3_MUL = 3;

  function automatic logic [MAX_STRB_W*8-1:0] bytemask(input logic [MAX_STRB_W-1:0] strb);
    logic [MAX_STRB_W*8-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_STRB_W; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_stall_ctrl.sv
// Counts accepted beats and requests a one-cycle stall after every STALL_PERIOD of them.
// STALL_PERIOD = 0 never requests a stall.
module axis_stall_ctrl #(
  parameter int STALL_PERIOD = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic accept,
  input  logic clear,
  output logic stall
);

  localparam int CNT_W = $clog2(STALL_PERIOD + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

  logic [CNT_W-1:0] cnt;

  assign stall = (STALL_PERIOD > 0) && accept && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axis_pow3_checker.sv
// AXI4-Stream sink that checks each accepted beat, masked by tstrb, against a locally
// regenerated 1, 3, 9, 27... sequence and keeps saturating statistics plus first-error capture.
module axis_pow3_checker
  import axis_lab_pkg::*;
#(
  parameter int DATA_SIZE    = 32,
  parameter int COUNT_WIDTH  = 16,
  parameter int STALL_PERIOD = 0
) (
  input  logic                   s00_axis_aclk,
  input  logic                   s00_axis_aresetn,
  input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
  input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
  input  logic                   s00_axis_tvalid,
  output logic                   s00_axis_tready,
  input  logic                   s00_axis_tlast,
  input  logic                   chk_enable,
  input  logic                   chk_clear,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] first_err_beat,
  output logic [DATA_SIZE-1:0]   first_err_data,
  output logic                   err_flag,
  output logic                   done
);

  state_t               state, state_nxt;
  logic                 hs;
  logic                 stall_req;
  logic                 mismatch;
  logic [DATA_SIZE-1:0] exp_val;
  logic [DATA_SIZE-1:0] mask;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign hs       = s00_axis_tvalid && s00_axis_tready;
  assign mask     = DATA_SIZE'(bytemask(MAX_STRB_W'(s00_axis_tstrb)));
  assign mismatch = |((s00_axis_tdata ^ exp_val) & mask);
  assign done     = (state == DONE);

  axis_stall_ctrl #(
    .STALL_PERIOD(STALL_PERIOD)
  ) u_stall (
    .clk   (s00_axis_aclk),
    .rstn  (s00_axis_aresetn),
    .accept(hs),
    .clear (chk_clear),
    .stall (stall_req)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (chk_enable) state_nxt = RUN;
      RUN: begin
        if (hs && s00_axis_tlast) state_nxt = DONE;
        else if (!chk_enable)     state_nxt = IDLE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (chk_clear) state_nxt = IDLE;
  end

  // Control: state and registered ready
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state           <= IDLE;
      s00_axis_tready <= 1'b0;
    end else begin
      state           <= state_nxt;
      s00_axis_tready <= (state_nxt == RUN) && !stall_req;
    end
  end

  // Statistics: a clear on the handshake edge discards that beat
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn || chk_clear) begin
      exp_val        <= DATA_SIZE'(1);
      beat_count     <= '0;
      error_count    <= '0;
      first_err_beat <= '0;
      first_err_data <= '0;
      err_flag       <= 1'b0;
    end else if (hs) begin
      exp_val    <= exp_val * DATA_SIZE'(POW3_MUL);
      beat_count <= sat_inc(beat_count);
      if (mismatch) begin
        error_count <= sat_inc(error_count);
        err_flag    <= 1'b1;
        if (!err_flag) begin
          first_err_beat <= beat_count;
          first_err_data <= s00_axis_tdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_pow3_checker.sv
// Self-checking bench for axis_pow3_checker: directed scenarios plus randomized beats
// compared against a power-of-3 reference model; a second instance exercises back-pressure.
module tb_axis_pow3_checker;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tvalid, tlast, en, clr;
  logic        tready, err_flag, done;
  logic [15:0] beat_count, error_count, first_err_beat;
  logic [31:0] first_err_data;

  logic [31:0] b_tdata;
  logic [3:0]  b_tstrb;
  logic        b_tvalid, b_tlast, b_en, b_clr;
  logic        b_tready, b_err_flag, b_done;
  logic [15:0] b_beat_count, b_error_count, b_first_err_beat;
  logic [31:0] b_first_err_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          m_k, m_beats, m_errs, m_fbeat;
  bit          m_flag;
  logic [31:0] m_fdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  axis_pow3_checker #(.DATA_SIZE(32), .COUNT_WIDTH(16), .STALL_PERIOD(0)) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rstn), .s00_axis_tdata(tdata),
    .s00_axis_tstrb(tstrb), .s00_axis_tvalid(tvalid), .s00_axis_tready(tready),
    .s00_axis_tlast(tlast), .chk_enable(en), .chk_clear(clr),
    .beat_count(beat_count), .error_count(error_count), .first_err_beat(first_err_beat),
    .first_err_data(first_err_data), .err_flag(err_flag), .done(done));

  axis_pow3_checker #(.DATA_SIZE(32), .COUNT_WIDTH(16), .STALL_PERIOD(2)) dut_bp (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rstn), .s00_axis_tdata(b_tdata),
    .s00_axis_tstrb(b_tstrb), .s00_axis_tvalid(b_tvalid), .s00_axis_tready(b_tready),
    .s00_axis_tlast(b_tlast), .chk_enable(b_en), .chk_clear(b_clr),
    .beat_count(b_beat_count), .error_count(b_error_count), .first_err_beat(b_first_err_beat),
    .first_err_data(b_first_err_data), .err_flag(b_err_flag), .done(b_done));

  function automatic logic [31:0] pow3(input int k);
    longint unsigned v = 1;
    for (int i = 0; i < k; i++) v = (v * 3) % 64'h1_0000_0000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  task automatic model_clear();
    m_k = 0; m_beats = 0; m_errs = 0; m_fbeat = 0; m_flag = 0; m_fdata = '0;
  endtask

  task automatic model_accept(input logic [31:0] d, input logic [3:0] s);
    if (((d ^ pow3(m_k)) & strb_mask(s)) != 0) begin
      if (!m_flag) begin m_fbeat = m_beats; m_fdata = d; end
      m_flag = 1; m_errs++;
    end
    m_beats++; m_k++;
  endtask

  task automatic do_clear();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    model_clear();
  endtask

  // Presents one beat and waits (bounded) until it is accepted.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic last);
    bit ok = 0;
    tdata = d; tstrb = s; tlast = last; tvalid = 1'b1;
    for (int w = 0; w < 20 && !ok; w++) begin
      if (tready) ok = 1;
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_timeout got=no_accept want=accept data=%h", d); end
    else model_accept(d, s);
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 0; clr = 0; tvalid = 0; tlast = 0; tdata = '0; tstrb = '0;
    b_en = 0; b_clr = 0; b_tvalid = 0; b_tlast = 0; b_tdata = '0; b_tstrb = 4'hF;
    repeat (3) @(posedge clk); #1;
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%b want=0", tready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL rst_err_flag got=%b want=0", err_flag); end
    checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL rst_beats got=%0d want=0", beat_count); end
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL rst_errs got=%0d want=0", error_count); end
    checks++; if (first_err_beat !== 16'd0 || first_err_data !== 32'd0) begin errors++;
      $display("FAIL rst_capture got=%0d/%h want=0/0", first_err_beat, first_err_data); end
    checks++; if (b_tready !== 1'b0) begin errors++; $display("FAIL rst_bp_tready got=%b want=0", b_tready); end
    rstn = 1'b1;
    model_clear();
  endtask

  task automatic test_clean();
    en = 1'b1; @(posedge clk); #1;
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL run_entry_tready got=%b want=1", tready); end
    send_beat(32'd1, 4'hF, 0); send_beat(32'd3, 4'hF, 0);
    send_beat(32'd9, 4'hF, 0); send_beat(32'd27, 4'hF, 1);
    checks++; if (beat_count !== 16'd4) begin errors++; $display("FAIL clean_beats got=%0d want=4", beat_count); end
    checks++; if (error_count !== 16'd0) begin errors++; $display("FAIL clean_errs got=%0d want=0", error_count); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL clean_done got=%b want=1", done); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL clean_tready got=%b want=0", tready); end
  endtask

  task automatic test_bad_beat();
    do_clear();
    checks++; if (done !== 1'b0 || tready !== 1'b0) begin errors++;
      $display("FAIL clear_idle got=done%b/rdy%b want=0/0", done, tready); end
    send_beat(32'd1, 4'hF, 0); send_beat(32'd3, 4'hF, 0);
    send_beat(32'd10, 4'hF, 0);
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL bad_flag_rise got=%b want=1", err_flag); end
    send_beat(32'd27, 4'hF, 1);
    checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL bad_errs got=%0d want=1", error_count); end
    checks++; if (first_err_beat !== 16'd2) begin errors++; $display("FAIL bad_first_beat got=%0d want=2", first_err_beat); end
    checks++; if (first_err_data !== 32'd10) begin errors++; $display("FAIL bad_first_data got=%0d want=10", first_err_data); end
    checks++; if (beat_count !== 16'd4 || done !== 1'b1) begin errors++;
      $display("FAIL bad_end got=%0d/%b want=4/1", beat_count, done); end
  endtask

  task automatic test_strobe();
    do_clear();
    send_beat(32'd1, 4'hF, 0); send_beat(32'd3, 4'hF, 0);
    send_beat(32'hFFFFFF09, 4'b0001, 0);
    checks++; if (error_count !== 16'd0 || err_flag !== 1'b0) begin errors++;
      $display("FAIL strb_masked got=%0d/%b want=0/0", error_count, err_flag); end
    send_beat(32'hFFFFFF1B, 4'hF, 0);
    checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL strb_full got=%0d want=1", error_count); end
    checks++; if (first_err_beat !== 16'd3 || first_err_data !== 32'hFFFFFF1B) begin errors++;
      $display("FAIL strb_capture got=%0d/%h want=3/ffffff1b", first_err_beat, first_err_data); end
    send_beat(32'hDEADBEEF, 4'h0, 0);
    checks++; if (beat_count !== 16'd5 || error_count !== 16'd1) begin errors++;
      $display("FAIL strb_zero got=%0d/%0d want=5/1", beat_count, error_count); end
  endtask

  task automatic test_random();
    int n = 40;
    logic [31:0] d;
    logic [3:0]  s;
    do_clear();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      d = pow3(m_k);
      if ($urandom_range(0, 3) == 0) d = d ^ (32'h1 << $urandom_range(0, 31));
      s = 4'($urandom_range(0, 15));
      send_beat(d, s, (i == n - 1));
      checks++; if (beat_count !== 16'(m_beats) || error_count !== 16'(m_errs) || err_flag !== m_flag) begin
        errors++; $display("FAIL rand_beat%0d got=%0d/%0d/%b want=%0d/%0d/%b", i,
          beat_count, error_count, err_flag, m_beats, m_errs, m_flag); end
    end
    checks++; if (m_flag && (first_err_beat !== 16'(m_fbeat) || first_err_data !== m_fdata)) begin errors++;
      $display("FAIL rand_capture got=%0d/%h want=%0d/%h", first_err_beat, first_err_data, m_fbeat, m_fdata); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand_done got=%b want=1", done); end
  endtask

  task automatic test_enable_hold();
    do_clear();
    send_beat(32'd1, 4'hF, 0); send_beat(32'd3, 4'hF, 0);
    en = 1'b0; @(posedge clk); #1;
    tdata = 32'd9; tstrb = 4'hF; tvalid = 1'b1;
    repeat (3) @(posedge clk); #1;
    tvalid = 1'b0;
    checks++; if (tready !== 1'b0 || beat_count !== 16'd2) begin errors++;
      $display("FAIL hold_idle got=rdy%b/%0d want=0/2", tready, beat_count); end
    en = 1'b1;
    send_beat(32'd9, 4'hF, 0);
    checks++; if (beat_count !== 16'd3 || error_count !== 16'd0) begin errors++;
      $display("FAIL hold_resume got=%0d/%0d want=3/0", beat_count, error_count); end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [31:0] d;
    do_clear();
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 22; k++) begin
      d = (k == 20) ? 32'd3486784401 : (k == 21) ? 32'd1870418611 : pow3(k);
      send_beat(d, 4'hF, (k == 21));
    end
    checks++; if (cyc - c0 !== 22) begin errors++; $display("FAIL b2b_cycles got=%0d want=22", cyc - c0); end
    checks++; if (error_count !== 16'd0 || beat_count !== 16'd22) begin errors++;
      $display("FAIL wrap_counts got=%0d/%0d want=0/22", error_count, beat_count); end
  endtask

  task automatic test_clear_handshake();
    do_clear();
    send_beat(32'd1, 4'hF, 0); send_beat(32'd3, 4'hF, 0);
    checks++; if (tready !== 1'b1) begin errors++; $display("FAIL clrhs_pre got=%b want=1", tready); end
    tdata = 32'd9; tstrb = 4'hF; tvalid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; tvalid = 1'b0;
    model_clear();
    checks++; if (beat_count !== 16'd0 || error_count !== 16'd0) begin errors++;
      $display("FAIL clrhs_counts got=%0d/%0d want=0/0", beat_count, error_count); end
    checks++; if (tready !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL clrhs_idle got=%b/%b want=0/0", tready, done); end
    send_beat(32'd1, 4'hF, 0); send_beat(32'd3, 4'hF, 0);
    checks++; if (beat_count !== 16'd2 || error_count !== 16'd0) begin errors++;
      $display("FAIL clrhs_restart got=%0d/%0d want=2/0", beat_count, error_count); end
  endtask

  task automatic test_reset_mid();
    send_beat(32'd5, 4'hF, 0);
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL rmid_pre got=%b want=1", err_flag); end
    tdata = 32'd27; tstrb = 4'hF; tvalid = 1'b1; rstn = 1'b0;
    @(posedge clk); #1;
    checks++; if (tready !== 1'b0 || done !== 1'b0 || err_flag !== 1'b0) begin errors++;
      $display("FAIL rmid_ctrl got=%b/%b/%b want=0/0/0", tready, done, err_flag); end
    checks++; if (beat_count !== 0 || error_count !== 0 || first_err_beat !== 0 || first_err_data !== 0) begin
      errors++; $display("FAIL rmid_stats got=%0d/%0d/%0d/%h want=0/0/0/0",
        beat_count, error_count, first_err_beat, first_err_data); end
    rstn = 1'b1; tvalid = 1'b0;
    model_clear();
    send_beat(32'd1, 4'hF, 1);
    checks++; if (beat_count !== 16'd1 || error_count !== 16'd0 || done !== 1'b1) begin errors++;
      $display("FAIL rmid_after got=%0d/%0d/%b want=1/0/1", beat_count, error_count, done); end
  endtask

  task automatic test_backpressure();
    int nb = 0;
    bit want, seen = 0;
    b_en = 1'b1; b_tvalid = 1'b1; b_tdata = pow3(0); b_tstrb = 4'hF;
    for (int w = 0; w < 5 && !seen; w++) begin
      @(posedge clk); #1;
      if (b_tready) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_start got=no_ready want=ready"); end
    for (int i = 0; i < 12; i++) begin
      want = (i % 3 != 2);
      checks++; if (b_tready !== want) begin errors++;
        $display("FAIL bp_tready_c%0d got=%b want=%b", i, b_tready, want); end
      @(posedge clk); #1;
      if (want) nb++;
      checks++; if (b_beat_count !== 16'(nb)) begin errors++;
        $display("FAIL bp_beats_c%0d got=%0d want=%0d", i, b_beat_count, nb); end
      b_tdata = pow3(nb);
    end
    b_tvalid = 1'b0;
    checks++; if (b_error_count !== 16'd0) begin errors++; $display("FAIL bp_errs got=%0d want=0", b_error_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clean();
    test_bad_beat();
    test_strobe();
    test_random();
    test_enable_hold();
    test_back_to_back();
    test_clear_handshake();
    test_reset_mid();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_pow3_checker.md
# axis_pow3_checker

AXI4-Stream slave that sits directly downstream of the power-of-3 stream generator and consumes its output. It accepts beats under a programmable back-pressure pattern and checks each beat, byte-masked by `tstrb`, against an internally regenerated power-of-3 sequence. It also maintains saturating beat and error counters and first-error capture registers for the lab bench.

## Interface
Parameters:
- `DATA_SIZE`, 32: stream data width in bits; must be a multiple of 8.
- `COUNT_WIDTH`, 16: width of the beat and error counters.
- `STALL_PERIOD`, 0: back-pressure period. 0 means `tready` is never throttled. N>0 means one stall cycle after every N accepted beats.

Ports:
- `s00_axis_aclk`, in, 1: single clock; all logic is on the rising edge.
- `s00_axis_aresetn`, in, 1: reset, synchronous, active-low.
- `s00_axis_tdata`, in, DATA_SIZE: stream data.
- `s00_axis_tstrb`, in, DATA_SIZE/8: byte qualifiers. A 1 bit means that byte is compared.
- `s00_axis_tvalid`, in, 1: beat valid.
- `s00_axis_tready`, out, 1: registered ready.
- `s00_axis_tlast`, in, 1: end of packet. Sampled only on a handshake.
- `chk_enable`, in, 1: run/hold.
- `chk_clear`, in, 1: synchronous soft clear.
- `beat_count`, out, COUNT_WIDTH: accepted beats.
- `error_count`, out, COUNT_WIDTH: mismatching beats.
- `first_err_beat`, out, COUNT_WIDTH: zero-based index of the first mismatch.
- `first_err_data`, out, DATA_SIZE: `tdata` of the first mismatch.
- `err_flag`, out, 1: sticky error flag.
- `done`, out, 1: a `tlast` beat has been accepted.

## Operation
- **Handshake rule.** A beat transfers on an edge where `tvalid && tready` is sampled high.
- **Expected-value register** `exp`:
  - Reset and clear value is 1.
  - After every accepted beat, `exp <= exp*3` truncated to DATA_SIZE bits (mod 2^DATA_SIZE).
  - `exp` always advances from its own value, never from the received data, so one bad beat does not cascade into further errors.
- **Mismatch rule.**
  - A beat mismatches when `((tdata ^ exp) & bytemask(tstrb)) != 0`.
  - A beat with `tstrb == 0` is counted and advances `exp`, but never errors.
- **States:**
  - `IDLE`: `tready` = 0. Moves to `RUN` when `chk_enable` = 1.
  - `RUN`:
    - `tready` = 1 unless a stall is pending or `chk_enable` = 0.
    - If `chk_enable` falls, return to `IDLE`; counters and `exp` are held.
    - On acceptance of a beat with `tlast` = 1, move to `DONE`.
  - `DONE`: `tready` = 0 and `done` = 1. Stays in `DONE` until `chk_clear` or reset.
- **Stall control.** When STALL_PERIOD = N > 0, the cycle after the N-th accepted beat since the last stall has `tready` = 0 for exactly one cycle, then the count restarts.
- **Counters.**
  - `beat_count` and `error_count` saturate at all-ones and never wrap.
  - `first_err_beat` and `first_err_data` load only when `err_flag` is 0 at the erroring beat.
- **`chk_clear`.**
  - Returns the block to `IDLE`, clears all counters, flags and capture registers, and sets `exp` to 1.
  - It has priority over a same-cycle handshake. That beat is consumed but discarded from statistics.
- **Reset values** (reset asserted at any time, including mid-packet, forces these on the next edge):
  - `tready` = 0, `done` = 0, `err_flag` = 0.
  - All counters and capture registers = 0.
  - `exp` = 1, state = `IDLE`, stall counter = 0.

## Timing
- `tready` is a registered output. It reflects state and stall decisions one cycle after their cause.
- Status outputs update on the edge that samples the handshake, so they are visible the following cycle.
- `err_flag` rises one cycle after the bad beat is sampled.
- `done` rises one cycle after the `tlast` beat. `tready` is 0 from that same cycle.
- With STALL_PERIOD = 0 and `tvalid` held high, the block accepts one beat per cycle indefinitely.
- Entering `RUN` from `IDLE` takes one cycle before `tready` = 1.

## Structure
- Shared package `axis_lab_pkg` holds:
  - the state enumeration (`IDLE`, `RUN`, `DONE`);
  - the `bytemask(strb)` function, which expands each `tstrb` bit to 8 bits;
  - the multiply-by-3 constant, shared with the generator.
- One sub-module, `axis_stall_ctrl`: a parameterised accepted-beat counter producing the `stall` request. It takes the accept pulse and clear as inputs.

## Test plan
- **Clean run.** Reset, enable, feed 1, 3, 9, 27 with `tstrb` = 4'hF, then `tlast` on the 4th beat → `beat_count` = 4, `error_count` = 0, `done` = 1, `tready` = 0.
- **Single bad beat.** Feed 1, 3, 10, 27 → `error_count` = 1, `first_err_beat` = 2, `first_err_data` = 10, `err_flag` = 1; beat 27 passes.
- **Strobe masking.** At expected 9, send `tdata` = 32'hFFFFFF09 with `tstrb` = 4'b0001 → no error. Same data with `tstrb` = 4'hF → error. Send `tstrb` = 0 with garbage data → counted, no error.
- **Wrap-around.** 22 consecutive correct beats with DATA_SIZE = 32 → beat 20 = 3486784401, beat 21 = 1870418611 (3^21 mod 2^32) accepted without error.
- **Back-pressure.** STALL_PERIOD = 2, `tvalid` held high → `tready` pattern 1, 1, 0, 1, 1, 0…; `beat_count` increments only on high cycles.
- **Clear and reset.**
  - Assert `chk_clear` in the same cycle as a handshake mid-packet → counters 0, state `IDLE`, next accepted beat must be 1.
  - Assert reset mid-packet → all outputs at their reset values on the next cycle.
